reorder_buffer: RTL and testbench

- Circular reorder buffer on the receiving end of the dispatch→ROB interface (dest_reg / fire_valid / wb_en).
- Allocates one entry per dispatched instruction in program order and returns the entry index to dispatch.
- Marks entries done on FU completion and retires them in order, one per cycle, toward the rename/free-list and architectural state.
- Sits between dispatch and commit in the core, alongside the scheduler, which receives the same rob_entry_idx.

---
 rtl/reorder_buffer_pkg.sv | 23 ++
 rtl/reorder_buffer_if.sv | 45 ++++
 rtl/reorder_buffer_rob_ptr.sv | 20 ++
 rtl/reorder_buffer.sv | 104 ++++++++++
 tb/tb_reorder_buffer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared parameters and entry payload for the reorder buffer and its dispatch/commit interface.
package reorder_buffer_pkg;

  localparam int unsigned ROB_ENTRIES = 32;
  localparam int unsigned NUM_AREGS   = 32;
  localparam int unsigned NUM_PREGS   = 64;
  localparam int unsigned NUM_CMPL    = 2;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned IDX_W       = $clog2(ROB_ENTRIES);
  localparam int unsigned CNT_W       = IDX_W + 1;
  localparam int unsigned AREG_W      = $clog2(NUM_AREGS);
  localparam int unsigned PREG_W      = $clog2(NUM_PREGS);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [AREG_W-1:0] areg;
    logic [PREG_W-1:0] preg;
    logic              wb_en;
    logic [PC_W-1:0]   pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, completion, commit and status signals between the core and the reorder buffer.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
();

  logic                      disp_fire_valid;
  logic [AREG_W-1:0]         disp_dest_reg;
  logic [PREG_W-1:0]         disp_dst_preg;
  logic                      disp_wb_en;
  logic [PC_W-1:0]           disp_pc;
  logic                      disp_ready;
  logic [IDX_W-1:0]          disp_rob_idx;

  logic [NUM_CMPL-1:0]       cmpl_valid;
  logic [NUM_CMPL*IDX_W-1:0] cmpl_rob_idx;

  logic                      commit_valid;
  logic [AREG_W-1:0]         commit_areg;
  logic [PREG_W-1:0]         commit_preg;
  logic                      commit_wb_en;
  logic [PC_W-1:0]           commit_pc;
  logic [IDX_W-1:0]          commit_rob_idx;

  logic                      flush;
  logic [CNT_W-1:0]          rob_count;
  logic                      rob_empty;
  logic                      rob_full;

  modport master (
    output disp_fire_valid, disp_dest_reg, disp_dst_preg, disp_wb_en, disp_pc,
    output cmpl_valid, cmpl_rob_idx, flush,
    input  disp_ready, disp_rob_idx,
    input  commit_valid, commit_areg, commit_preg, commit_wb_en, commit_pc, commit_rob_idx,
    input  rob_count, rob_empty, rob_full
  );

  modport slave (
    input  disp_fire_valid, disp_dest_reg, disp_dst_preg, disp_wb_en, disp_pc,
    input  cmpl_valid, cmpl_rob_idx, flush,
    output disp_ready, disp_rob_idx,
    output commit_valid, commit_areg, commit_preg, commit_wb_en, commit_pc, commit_rob_idx,
    output rob_count, rob_empty, rob_full
  );

endinterface

// File: rtl/reorder_buffer_rob_ptr.sv
// Wrapping W-bit ring pointer; clear has priority over increment.
module rob_ptr #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate at tail, out-of-order completion, in-order retire at head.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  reorder_buffer_if.slave  rob
);

  rob_entry_t       entries [ROB_ENTRIES];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] cmpl_idx [NUM_CMPL];
  logic             full;
  logic             accept;
  logic             commit;
  rob_entry_t       head_entry;

  // Status and dispatch handshake depend only on registered occupancy.
  assign full             = (count == CNT_W'(ROB_ENTRIES));
  assign accept           = rob.disp_fire_valid && !full;
  assign rob.disp_ready   = !full;
  assign rob.disp_rob_idx = tail;
  assign rob.rob_count    = count;
  assign rob.rob_empty    = (count == '0);
  assign rob.rob_full     = full;

  assign head_entry         = entries[head];
  assign commit             = head_entry.valid && head_entry.done;
  assign rob.commit_valid   = commit;
  assign rob.commit_areg    = head_entry.areg;
  assign rob.commit_preg    = head_entry.preg;
  assign rob.commit_wb_en   = head_entry.wb_en;
  assign rob.commit_pc      = head_entry.pc;
  assign rob.commit_rob_idx = head;

  for (genvar p = 0; p < NUM_CMPL; p++) begin : g_cidx
    assign cmpl_idx[p] = rob.cmpl_rob_idx[p*IDX_W +: IDX_W];
  end

  rob_ptr #(.W(IDX_W)) u_head (
    .clk   (clk),
    .rst   (rst),
    .clear (rob.flush),
    .inc   (commit),
    .ptr   (head)
  );

  rob_ptr #(.W(IDX_W)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .clear (rob.flush),
    .inc   (accept),
    .ptr   (tail)
  );

  always_ff @(posedge clk) begin
    if (rst || rob.flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(accept) - CNT_W'(commit);
    end
  end

  // Per-entry state; allocate and retire never target the same slot in one cycle.
  for (genvar i = 0; i < ROB_ENTRIES; i++) begin : g_ent
    rob_entry_t ent;
    logic       cmpl_hit;

    always_comb begin
      cmpl_hit = 1'b0;
      for (int p = 0; p < NUM_CMPL; p++) begin
        if (rob.cmpl_valid[p] && (cmpl_idx[p] == IDX_W'(i))) begin
          cmpl_hit = 1'b1;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ent <= '0;
      end else if (rob.flush) begin
        ent.valid <= 1'b0;
        ent.done  <= 1'b0;
      end else if (accept && (tail == IDX_W'(i))) begin
        ent.valid <= 1'b1;
        ent.done  <= 1'b0;
        ent.areg  <= rob.disp_dest_reg;
        ent.preg  <= rob.disp_dst_preg;
        ent.wb_en <= rob.disp_wb_en;
        ent.pc    <= rob.disp_pc;
      end else if (commit && (head == IDX_W'(i))) begin
        ent.valid <= 1'b0;
        ent.done  <= 1'b0;
      end else if (cmpl_hit && ent.valid) begin
        ent.done <= 1'b1;
      end
    end

    assign entries[i] = ent;
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: program-order queue model, directed scenarios plus random traffic.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  typedef struct {
    int          idx;
    int          areg;
    int          preg;
    bit          wb;
    int unsigned pc;
    bit          done;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if rob_if ();

  reorder_buffer dut (
    .clk (clk),
    .rst (rst),
    .rob (rob_if.slave)
  );

  rec_t mq[$];
  rec_t exp_q[$];
  int   next_idx = 0;
  bit   known    = 1'b0;
  int   tests    = 0;
  int   fails    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every retirement must match the oldest outstanding dispatch.
  always @(negedge clk) begin
    if (rob_if.commit_valid === 1'b1 && rob_if.flush !== 1'b1 && rst !== 1'b1 && known) begin
      rec_t e;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL commit_unexpected: got commit idx %0d expected no commit", rob_if.commit_rob_idx);
      end else begin
        e = exp_q.pop_front();
        chk("commit_idx",  64'(rob_if.commit_rob_idx), 64'(e.idx));
        chk("commit_areg", 64'(rob_if.commit_areg),    64'(e.areg));
        chk("commit_preg", 64'(rob_if.commit_preg),    64'(e.preg));
        chk("commit_wb",   64'(rob_if.commit_wb_en),   64'(e.wb));
        chk("commit_pc",   64'(rob_if.commit_pc),      64'(e.pc));
      end
    end
  end

  task automatic cycle(input bit rs, input bit fire, input int areg, input int preg,
                       input bit wb, input int unsigned pc, input bit [1:0] cv,
                       input int c0, input int c1, input bit fl);
    bit   com;
    bit   acc;
    int   cidx [2];
    rec_t r;
    @(posedge clk);
    #1;
    rst                    = rs;
    rob_if.disp_fire_valid = fire;
    rob_if.disp_dest_reg   = AREG_W'(areg);
    rob_if.disp_dst_preg   = PREG_W'(preg);
    rob_if.disp_wb_en      = wb;
    rob_if.disp_pc         = PC_W'(pc);
    rob_if.cmpl_valid      = cv;
    rob_if.cmpl_rob_idx    = {IDX_W'(c1), IDX_W'(c0)};
    rob_if.flush           = fl;
    @(negedge clk);
    if (known) begin
      chk("rob_count",    64'(rob_if.rob_count),    64'(mq.size()));
      chk("rob_empty",    64'(rob_if.rob_empty),    64'(mq.size() == 0));
      chk("rob_full",     64'(rob_if.rob_full),     64'(mq.size() == ROB_ENTRIES));
      chk("disp_ready",   64'(rob_if.disp_ready),   64'(mq.size() < ROB_ENTRIES));
      chk("disp_rob_idx", 64'(rob_if.disp_rob_idx), 64'(next_idx));
      chk("commit_valid", 64'(rob_if.commit_valid), 64'(mq.size() > 0 && mq[0].done));
    end
    #1;
    if (rs || fl) begin
      mq.delete();
      exp_q.delete();
      next_idx = 0;
      known    = 1'b1;
    end else begin
      com     = (mq.size() > 0) && mq[0].done;
      acc     = fire && (mq.size() < ROB_ENTRIES);
      cidx[0] = c0;
      cidx[1] = c1;
      for (int p = 0; p < 2; p++) begin
        if (cv[p]) begin
          for (int j = 0; j < mq.size(); j++) begin
            if (mq[j].idx == cidx[p]) mq[j].done = 1'b1;
          end
        end
      end
      if (com) void'(mq.pop_front());
      if (acc) begin
        r = '{idx: next_idx, areg: areg, preg: preg, wb: wb, pc: pc, done: 1'b0};
        mq.push_back(r);
        exp_q.push_back(r);
        next_idx = (next_idx + 1) % ROB_ENTRIES;
      end
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic disp(input int areg, input int preg, input int unsigned pc);
    cycle(0, 1, areg, preg, 1, pc, 2'b00, 0, 0, 0);
  endtask

  task automatic cmpl(input bit [1:0] cv, input int c0, input int c1);
    cycle(0, 0, 0, 0, 0, 0, cv, c0, c1, 0);
  endtask

  task automatic do_flush();
    cycle(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
  endtask

  initial begin
    int          c0;
    int          c1;
    int          crate;
    bit [1:0]    cv;
    rob_if.disp_fire_valid = 1'b0;
    rob_if.disp_dest_reg   = '0;
    rob_if.disp_dst_preg   = '0;
    rob_if.disp_wb_en      = 1'b0;
    rob_if.disp_pc         = '0;
    rob_if.cmpl_valid      = '0;
    rob_if.cmpl_rob_idx    = '0;
    rob_if.flush           = 1'b0;

    // Reset, single dispatch/complete/commit
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    cycle(0, 1, 1, 33, 1, 32'h0, 2'b00, 0, 0, 0);
    cmpl(2'b01, 0, 0);
    idle();
    idle();
    idle();

    // Out-of-order completion, in-order retirement
    do_flush();
    disp(2, 40, 32'h100);
    disp(3, 41, 32'h104);
    disp(4, 42, 32'h108);
    cmpl(2'b01, 2, 0);
    cmpl(2'b10, 0, 1);
    idle();
    cmpl(2'b01, 0, 0);
    repeat (4) idle();

    // Fill, blocked dispatch, commit vs dispatch in a full ROB, wrap
    do_flush();
    for (int i = 0; i < ROB_ENTRIES; i++) disp(i % NUM_AREGS, i + 10, 32'h1000 + 4 * i);
    disp(7, 7, 32'hdead);
    cmpl(2'b01, 0, 0);
    disp(8, 8, 32'hbeef);
    disp(9, 9, 32'hcafe);
    idle();
    for (int i = 1; i < ROB_ENTRIES; i += 2) cmpl(2'b11, i, (i + 1) % ROB_ENTRIES);
    repeat (ROB_ENTRIES + 2) idle();

    // Duplicate completions and completion to an invalid entry
    do_flush();
    for (int i = 0; i < 8; i++) disp(i + 1, i + 20, 32'h2000 + 4 * i);
    cmpl(2'b11, 5, 5);
    cmpl(2'b01, 20, 0);
    repeat (3) idle();
    cmpl(2'b11, 1, 2);
    cmpl(2'b11, 3, 4);
    cmpl(2'b11, 6, 7);
    cmpl(2'b01, 0, 0);
    repeat (10) idle();

    // Flush while the head is ready to retire
    do_flush();
    for (int i = 0; i < 4; i++) disp(i + 5, i + 50, 32'h3000 + 4 * i);
    cmpl(2'b01, 0, 0);
    do_flush();
    idle();
    idle();

    // Random traffic; completion rate varies by phase so the ROB both fills and drains
    for (int n = 0; n < 3000; n++) begin
      crate = ((n / 400) % 2 == 0) ? 25 : 85;
      cv    = '0;
      c0    = 0;
      c1    = 0;
      for (int p = 0; p < 2; p++) begin
        int c;
        c = int'($urandom_range(ROB_ENTRIES - 1));
        if (mq.size() > 0 && $urandom_range(99) < 85) c = mq[$urandom_range(mq.size() - 1)].idx;
        if ($urandom_range(99) < crate) cv[p] = 1'b1;
        if (p == 0) c0 = c; else c1 = c;
      end
      cycle(($urandom_range(999) == 0), ($urandom_range(99) < 60),
            int'($urandom_range(NUM_AREGS - 1)), int'($urandom_range(NUM_PREGS - 1)),
            1'($urandom_range(1)), $urandom(), cv, c0, c1, ($urandom_range(249) == 0));
    end

    // Drain
    for (int n = 0; n < 3 * ROB_ENTRIES && mq.size() > 0; n++) begin
      c0 = mq[0].idx;
      c1 = (mq.size() > 1) ? mq[1].idx : c0;
      cmpl(2'b11, c0, c1);
    end
    repeat (4) idle();
    chk("drained_count", 64'(rob_if.rob_count), 64'(0));
    chk("drained_sb",    64'(exp_q.size()),     64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
